mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between two requesters: the fetch step (requester 0) and the memory step (requester 1, loads/stores).
- Replaces direct addressing of memory by the fetch step. Sequences each access through request/grant/response phases with a fixed memory read latency.
- Returns read data, or a write acknowledge, to the requester that won arbitration.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LATENCY, 1, cycles from mem_en_o to mem_rdata_i valid; legal range 1..15.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- fetch_req_i  in  1  fetch read request; held until fetch_gnt_o
- fetch_addr_i  in  ADDR_W  fetch address (PC)
- fetch_gnt_o  out  1  one-cycle grant pulse; address consumed
- fetch_valid_o  out  1  one-cycle pulse; fetch_rdata_o valid
- fetch_rdata_o  out  DATA_W  instruction word
- data_req_i  in  1  data request; held until data_gnt_o
- data_we_i  in  1  1 = store, 0 = load
- data_addr_i  in  ADDR_W  data address
- data_wdata_i  in  DATA_W  store data
- data_be_i  in  DATA_W/8  store byte enables
- data_gnt_o  out  1  one-cycle grant pulse
- data_valid_o  out  1  one-cycle pulse; load data valid or store complete
- data_rdata_o  out  DATA_W  load data
- mem_en_o  out  1  memory access strobe, one cycle
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_be_o  out  DATA_W/8  memory byte enables
- mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- Reset (rst_i low, asynchronous): all outputs 0. State IDLE, owner = fetch, latency counter 0, priority pointer = data.
- States:
  - IDLE: on a clock edge with any request high, select a winner, register its address, write data, byte enables and we (fetch we = 0, be = all ones), record the owner, go to ISSUE.
  - ISSUE, one cycle: mem_en_o = 1, mem_* driven from registers, winner's gnt_o = 1. Load counter with MEM_LATENCY, go to WAIT.
  - WAIT: decrement counter each cycle. On the edge where it reaches 0, capture mem_rdata_i into the owner's rdata register, go to RESP.
  - RESP, one cycle: owner's valid_o = 1, go to IDLE.
- Latency: valid_o pulses exactly MEM_LATENCY+2 cycles after the first IDLE cycle in which the request is seen. With the default MEM_LATENCY = 1, that is 3 cycles. Throughput is one access per MEM_LATENCY+3 cycles.
- Arbitration, fixed priority (default build): data beats fetch when both request in the same IDLE cycle.
- Store: mem_rdata_i is not captured, so data_rdata_o holds its previous value. data_valid_o still pulses, as the write acknowledge.
- rdata_o registers hold their value until the next response to the same requester.
- Requests arriving during ISSUE/WAIT/RESP are not sampled; requesters keep req_i high until their gnt_o.
- A request dropped before grant is a protocol violation; the result is undefined.
- mem_en_o, gnt_o and valid_o are never high for both requesters at once. At most one gnt_o per transaction.
- Reset mid-transaction: the transaction is aborted, and no valid_o pulse follows reset release.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit priority pointer toggles to the non-winner after each grant. On simultaneous requests the pointer's requester wins. Reset pointer = data.
- Undefined: fixed data-over-fetch priority; the pointer register is not present.

Decomposition:
- Shared package/header (definitions.vh): state encodings, requester IDs (REQ_FETCH = 0, REQ_DATA = 1), default MEM_LATENCY.
- Sub-module arb_pick: the 2-requester priority/round-robin selector, combinational winner plus pointer register. The FSM stays in mem_port_arbiter.

Test Plan:
- Fetch-only read: fetch_req_i = 1 with addr 0x8000_0000, memory returns 0x0000_0013 → fetch_gnt_o in cycle 1, mem_addr_o = 0x8000_0000, fetch_valid_o in cycle 3 with fetch_rdata_o = 0x0000_0013, data_* silent.
- Store: data_req_i = 1, we = 1, addr 0x8000_1000, wdata 0xDEAD_BEEF, be = 4'b0011 → one mem_en_o with mem_we_o = 1, be 0011, matching data; data_valid_o pulses, data_rdata_o unchanged.
- Simultaneous requests in fixed-priority build: data serviced first and fetch granted in the next IDLE; fetch_valid_o lands 2×(MEM_LATENCY+3) − 1 cycles after the first request.
- Same stimulus with MEM_ARB_ROUND_ROBIN_EN, 4 back-to-back pairs → grant order data, fetch, data, fetch…; no requester waits more than one transaction.
- MEM_LATENCY = 4: fetch read → valid_o exactly 6 cycles after the request; mem_rdata_i is sampled only on the 4th cycle after mem_en_o, and garbage on other cycles is ignored.
- Assert rst_i low in WAIT → all outputs 0 immediately; after release, no stray valid_o; the next request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM states, requester IDs, defaults.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

  localparam int MEM_LATENCY_DEF = 1;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Two-requester winner select. MEM_ARB_ROUND_ROBIN_EN adds an alternating priority pointer;
// otherwise data always beats fetch.
module mem_port_arbiter_arb_pick
  import mem_port_arbiter_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    take_i,
`endif
  input  logic    fetch_req_i,
  input  logic    data_req_i,
  output req_id_e winner_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_id_e ptr_q;

  // Pointer hands priority to whoever lost the slot just taken.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      ptr_q <= REQ_DATA;
    else if (take_i) ptr_q <= (winner_o == REQ_DATA) ? REQ_FETCH : REQ_DATA;
  end

  always_comb begin
    if (fetch_req_i && data_req_i) winner_o = ptr_q;
    else if (data_req_i)           winner_o = REQ_DATA;
    else                           winner_o = REQ_FETCH;
  end
`else
  assign winner_o = data_req_i ? REQ_DATA : REQ_FETCH;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store via IDLE/ISSUE/WAIT/RESP sequencing.
// Optional round-robin priority under MEM_ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                fetch_req_i,
  input  logic [ADDR_W-1:0]   fetch_addr_i,
  output logic                fetch_gnt_o,
  output logic                fetch_valid_o,
  output logic [DATA_W-1:0]   fetch_rdata_o,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  output logic                data_gnt_o,
  output logic                data_valid_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                mem_en_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int BE_W = DATA_W / 8;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  req_id_e             owner_q, winner;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   fetch_rdata_q, data_rdata_q;
  logic                take, capture, issue, resp;

  assign take    = (state_q == ST_IDLE) && (fetch_req_i || data_req_i);
  assign capture = (state_q == ST_WAIT) && (cnt_q == CNT_W'(1));

  mem_port_arbiter_arb_pick u_pick (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .take_i      (take),
`endif
    .fetch_req_i (fetch_req_i),
    .data_req_i  (data_req_i),
    .winner_o    (winner)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:  if (fetch_req_i || data_req_i) state_d = ST_ISSUE;
      ST_ISSUE: begin
        cnt_d   = CNT_W'(MEM_LATENCY);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request fields are latched at selection so requesters may drop req_i right after gnt_o.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_q       <= REQ_FETCH;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      if (take) begin
        owner_q <= winner;
        if (winner == REQ_DATA) begin
          we_q    <= data_we_i;
          addr_q  <= data_addr_i;
          wdata_q <= data_wdata_i;
          be_q    <= data_be_i;
        end else begin
          we_q    <= 1'b0;
          addr_q  <= fetch_addr_i;
          wdata_q <= '0;
          be_q    <= '1;
        end
      end
      if (capture) begin
        if (owner_q == REQ_FETCH) fetch_rdata_q <= mem_rdata_i;
        else if (!we_q)           data_rdata_q  <= mem_rdata_i;
      end
    end
  end

  always_comb begin
    issue         = (state_q == ST_ISSUE);
    resp          = (state_q == ST_RESP);
    mem_en_o      = issue;
    mem_we_o      = issue && we_q;
    mem_addr_o    = issue ? addr_q  : '0;
    mem_wdata_o   = issue ? wdata_q : '0;
    mem_be_o      = issue ? be_q    : '0;
    fetch_gnt_o   = issue && (owner_q == REQ_FETCH);
    data_gnt_o    = issue && (owner_q == REQ_DATA);
    fetch_valid_o = resp  && (owner_q == REQ_FETCH);
    data_valid_o  = resp  && (owner_q == REQ_DATA);
    fetch_rdata_o = fetch_rdata_q;
    data_rdata_o  = data_rdata_q;
  end

endmodule
